sha3_miner_csr: RTL and testbench

Avalon-MM slave register bank that sits directly upstream of the SHA3-256 mining engine on the HPS lightweight bridge. It holds the header, difficulty, start nonce and control word that drive the engine. It captures the engine's solution and status coherently and turns the engine's completion into a maskable, acknowledgeable interrupt. It also counts run cycles so software can compute hash rate.

---
 rtl/sha3_miner_csr_if.sv | 28 ++
 rtl/sha3_miner_csr.sv | 190 +++++++++++++++++++
 tb/tb_sha3_miner_csr.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_miner_csr_if.sv
// Avalon-MM slave bus bundle between the HPS lightweight bridge and the
// SHA3 miner register bank.
interface sha3_miner_csr_if;
  logic [4:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata,
    input  avs_readdatavalid
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata,
    output avs_readdatavalid
  );
endinterface

// File: rtl/sha3_miner_csr.sv
// Register bank for the SHA3-256 mining engine: job setup, coherent solution
// capture, completion interrupt and a run-cycle counter for hash-rate math.
module sha3_miner_csr (
  input  logic                  clk,
  input  logic                  rst_n,
  sha3_miner_csr_if.slave       avs,
  output logic                  irq,
  output logic [255:0]          header,
  output logic [255:0]          difficulty,
  output logic [63:0]           start_nonce,
  output logic [18:0]           control,
  input  logic [63:0]           solution,
  input  logic [2:0]            status,
  input  logic                  miner_irq
);

  localparam logic [31:0] ID_WORD    = 32'h5348_4133;
  localparam logic [4:0]  A_NONCE_LO = 5'd16;
  localparam logic [4:0]  A_NONCE_HI = 5'd17;
  localparam logic [4:0]  A_CONTROL  = 5'd18;
  localparam logic [4:0]  A_STATUS   = 5'd19;
  localparam logic [4:0]  A_IRQ_CTL  = 5'd20;
  localparam logic [4:0]  A_SOL_LO   = 5'd21;
  localparam logic [4:0]  A_SOL_HI   = 5'd22;
  localparam logic [4:0]  A_CNT_LO   = 5'd23;
  localparam logic [4:0]  A_CNT_HI   = 5'd24;
  localparam logic [4:0]  A_ID       = 5'd25;

  logic [7:0][31:0] header_q, header_d;
  logic [7:0][31:0] diff_q, diff_d;
  logic [63:0]      nonce_q, nonce_d;
  logic [18:0]      control_q, control_d;
  logic             err_q, err_d;
  logic             pending_q, pending_d;
  logic             enable_q, enable_d;
  logic             irq_out_q, irq_out_d;
  logic             miner_irq_q, miner_irq_d;
  logic [63:0]      sol_q, sol_d;
  logic [63:0]      cnt_q, cnt_d;
  logic [31:0]      sol_shadow_q, sol_shadow_d;
  logic [31:0]      cnt_shadow_q, cnt_shadow_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             run_rise;
  logic             pend_clr;
  logic             miner_rise;
  logic             wr_blocked;
  logic [31:0]      rd_word;

  // Read mux: always reflects pre-write state so a same-cycle write is not seen.
  always_comb begin
    rd_word = '0;
    if (avs.avs_address[4:3] == 2'b00) begin
      rd_word = header_q[avs.avs_address[2:0]];
    end else if (avs.avs_address[4:3] == 2'b01) begin
      rd_word = diff_q[avs.avs_address[2:0]];
    end else begin
      case (avs.avs_address)
        A_NONCE_LO: rd_word = nonce_q[31:0];
        A_NONCE_HI: rd_word = nonce_q[63:32];
        A_CONTROL:  rd_word = {13'b0, control_q};
        A_STATUS:   rd_word = {27'b0, err_q, pending_q, status};
        A_IRQ_CTL:  rd_word = {30'b0, pending_q, enable_q};
        A_SOL_LO:   rd_word = sol_q[31:0];
        A_SOL_HI:   rd_word = sol_shadow_q;
        A_CNT_LO:   rd_word = cnt_q[31:0];
        A_CNT_HI:   rd_word = cnt_shadow_q;
        A_ID:       rd_word = ID_WORD;
        default:    rd_word = '0;
      endcase
    end
  end

  always_comb begin
    header_d     = header_q;
    diff_d       = diff_q;
    nonce_d      = nonce_q;
    control_d    = control_q;
    err_d        = err_q;
    enable_d     = enable_q;
    run_rise     = 1'b0;
    pend_clr     = 1'b0;
    miner_irq_d  = miner_irq;
    miner_rise   = miner_irq & ~miner_irq_q;
    // Job registers are frozen while the engine runs; the attempt is remembered.
    wr_blocked   = avs.avs_write & control_q[0] & (avs.avs_address <= A_NONCE_HI);

    if (wr_blocked) begin
      err_d = 1'b1;
    end else if (avs.avs_write) begin
      if (avs.avs_address[4:3] == 2'b00) begin
        header_d[avs.avs_address[2:0]] = avs.avs_writedata;
      end else if (avs.avs_address[4:3] == 2'b01) begin
        diff_d[avs.avs_address[2:0]] = avs.avs_writedata;
      end else begin
        case (avs.avs_address)
          A_NONCE_LO: nonce_d[31:0]  = avs.avs_writedata;
          A_NONCE_HI: nonce_d[63:32] = avs.avs_writedata;
          A_CONTROL: begin
            control_d = avs.avs_writedata[18:0];
            run_rise  = ~control_q[0] & avs.avs_writedata[0];
          end
          A_STATUS: begin
            if (avs.avs_writedata[4]) err_d = 1'b0;
          end
          A_IRQ_CTL: begin
            enable_d = avs.avs_writedata[0];
            pend_clr = avs.avs_writedata[1];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    sol_d        = sol_q;
    pending_d    = pending_q;
    sol_shadow_d = sol_shadow_q;
    cnt_shadow_d = cnt_shadow_q;

    if (control_q[0] && !miner_irq) cnt_d = cnt_q + 64'd1;
    if (run_rise) begin
      cnt_d = '0;
      sol_d = '0;
    end

    if (pend_clr || run_rise) pending_d = 1'b0;
    // A fresh completion outranks any simultaneous acknowledge.
    if (miner_rise) begin
      pending_d = 1'b1;
      sol_d     = solution;
    end

    // Low-word reads latch the matching high word so 64-bit values read coherently.
    if (avs.avs_read && avs.avs_address == A_SOL_LO) sol_shadow_d = sol_q[63:32];
    if (avs.avs_read && avs.avs_address == A_CNT_LO) cnt_shadow_d = cnt_q[63:32];

    rvalid_d  = avs.avs_read;
    rdata_d   = avs.avs_read ? rd_word : 32'b0;
    irq_out_d = pending_q & enable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header_q     <= '0;
      diff_q       <= '0;
      nonce_q      <= '0;
      control_q    <= '0;
      err_q        <= 1'b0;
      pending_q    <= 1'b0;
      enable_q     <= 1'b0;
      irq_out_q    <= 1'b0;
      miner_irq_q  <= 1'b0;
      sol_q        <= '0;
      cnt_q        <= '0;
      sol_shadow_q <= '0;
      cnt_shadow_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      header_q     <= header_d;
      diff_q       <= diff_d;
      nonce_q      <= nonce_d;
      control_q    <= control_d;
      err_q        <= err_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      irq_out_q    <= irq_out_d;
      miner_irq_q  <= miner_irq_d;
      sol_q        <= sol_d;
      cnt_q        <= cnt_d;
      sol_shadow_q <= sol_shadow_d;
      cnt_shadow_q <= cnt_shadow_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign header                = header_q;
  assign difficulty            = diff_q;
  assign start_nonce           = nonce_q;
  assign control               = control_q;
  assign irq                   = irq_out_q;
  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sha3_miner_csr.sv
// Directed bench for sha3_miner_csr: reset, register load, write protect,
// completion interrupt, set/ack race and cycle counter.
module tb_sha3_miner_csr;
  logic         clk;
  logic         rst_n;
  logic         irq;
  logic [255:0] header;
  logic [255:0] difficulty;
  logic [63:0]  start_nonce;
  logic [18:0]  control;
  logic [63:0]  solution;
  logic [2:0]   status;
  logic         miner_irq;

  int tests_run;
  int tests_failed;

  sha3_miner_csr_if bus ();

  sha3_miner_csr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .avs         (bus.slave),
    .irq         (irq),
    .header      (header),
    .difficulty  (difficulty),
    .start_nonce (start_nonce),
    .control     (control),
    .solution    (solution),
    .status      (status),
    .miner_irq   (miner_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, output logic [31:0] data);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    check("rvalid", {255'b0, bus.avs_readdatavalid}, 256'd1);
    data = bus.avs_readdata;
  endtask

  logic [31:0]  rdv;
  logic [255:0] exp_hdr;

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    rst_n             = 1'b0;
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    solution          = '0;
    status            = 3'b101;
    miner_irq         = 1'b0;

    // Reset, including an asynchronous reset in the middle of a read.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    wr(5'd0, 32'hA5A5_A5A5);
    wr(5'd18, 32'h1);
    bus.avs_address = 5'd25;
    bus.avs_read    = 1'b1;
    tick();
    check("pre_rst_rvalid", {255'b0, bus.avs_readdatavalid}, 256'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_header",  header, 256'd0);
    check("rst_control", {237'b0, control}, 256'd0);
    check("rst_rvalid",  {255'b0, bus.avs_readdatavalid}, 256'd0);
    check("rst_rdata",   {224'b0, bus.avs_readdata}, 256'd0);
    check("rst_irq",     {255'b0, irq}, 256'd0);
    bus.avs_read = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rd(5'd25, rdv);
    check("id", {224'b0, rdv}, {224'b0, 32'h5348_4133});
    tick();
    check("rvalid_drop", {255'b0, bus.avs_readdatavalid}, 256'd0);
    check("rdata_drop",  {224'b0, bus.avs_readdata}, 256'd0);

    // Register load and read-back.
    exp_hdr = '0;
    for (int n = 0; n < 8; n++) begin
      wr(5'(n), 32'h1111_1111 * 32'(n + 1));
      exp_hdr[32*n +: 32] = 32'h1111_1111 * 32'(n + 1);
    end
    check("header_bus", header, exp_hdr);
    wr(5'd16, 32'h0000_0000);
    wr(5'd17, 32'h0000_0001);
    check("start_nonce", {192'b0, start_nonce}, {192'b0, 64'h0000_0001_0000_0000});
    wr(5'd9, 32'hCAFE_F00D);
    check("diff_word1", {224'b0, difficulty[63:32]}, {224'b0, 32'hCAFE_F00D});
    rd(5'd2, rdv);
    check("rb_header2", {224'b0, rdv}, {224'b0, 32'h3333_3333});
    rd(5'd17, rdv);
    check("rb_nonce_hi", {224'b0, rdv}, 256'd1);
    // Same-cycle read and write of one address returns the old value.
    bus.avs_address   = 5'd0;
    bus.avs_writedata = 32'h7777_7777;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b1;
    tick();
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
    check("rw_same_old",  {224'b0, bus.avs_readdata}, {224'b0, 32'h1111_1111});
    check("rw_same_new",  {224'b0, header[31:0]}, {224'b0, 32'h7777_7777});
    wr(5'd0, 32'h1111_1111);
    wr(5'd18, 32'hFFFF_FFFE);
    rd(5'd18, rdv);
    check("rb_control_mask", {224'b0, rdv}, {224'b0, 32'h0007_FFFE});
    rd(5'd28, rdv);
    check("unmapped", {224'b0, rdv}, 256'd0);
    wr(5'd18, 32'h1);
    check("control_bus", {237'b0, control}, 256'd1);

    // Write protect while running.
    wr(5'd3, 32'hDEAD_BEEF);
    wr(5'd16, 32'h0000_FFFF);
    check("wp_header", header, exp_hdr);
    check("wp_nonce", {192'b0, start_nonce}, {192'b0, 64'h0000_0001_0000_0000});
    rd(5'd19, rdv);
    check("wp_err_set", {224'b0, rdv}, {224'b0, 32'h15});
    wr(5'd19, 32'h10);
    rd(5'd19, rdv);
    check("wp_err_clr", {224'b0, rdv}, {224'b0, 32'h05});

    // Completion interrupt and coherent solution read.
    wr(5'd20, 32'h1);
    solution  = 64'h0123_4567_89AB_CDEF;
    miner_irq = 1'b1;
    tick();
    miner_irq = 1'b0;
    check("irq_lat1", {255'b0, irq}, 256'd0);
    tick();
    check("irq_lat2", {255'b0, irq}, 256'd1);
    rd(5'd21, rdv);
    check("sol_lo", {224'b0, rdv}, {224'b0, 32'h89AB_CDEF});
    solution = 64'hFFFF_FFFF_FFFF_FFFF;
    rd(5'd22, rdv);
    check("sol_hi", {224'b0, rdv}, {224'b0, 32'h0123_4567});
    rd(5'd19, rdv);
    check("status_pending", {224'b0, rdv}, {224'b0, 32'h0D});
    wr(5'd20, 32'h3);
    check("irq_ack_edge", {255'b0, irq}, 256'd1);
    tick();
    check("irq_ack_low", {255'b0, irq}, 256'd0);

    // Enable raised while already pending.
    wr(5'd20, 32'h0);
    miner_irq = 1'b1;
    tick();
    miner_irq = 1'b0;
    tick();
    tick();
    check("irq_masked", {255'b0, irq}, 256'd0);
    wr(5'd20, 32'h1);
    check("irq_en_edge", {255'b0, irq}, 256'd0);
    tick();
    check("irq_en_next", {255'b0, irq}, 256'd1);

    // Acknowledge coinciding with a new completion: set wins.
    bus.avs_address   = 5'd20;
    bus.avs_writedata = 32'h3;
    bus.avs_write     = 1'b1;
    miner_irq         = 1'b1;
    tick();
    bus.avs_write = 1'b0;
    miner_irq     = 1'b0;
    tick();
    check("race_irq", {255'b0, irq}, 256'd1);
    rd(5'd20, rdv);
    check("race_pending", {224'b0, rdv}, {224'b0, 32'h3});
    wr(5'd20, 32'h3);
    tick();
    check("race_clear_irq", {255'b0, irq}, 256'd0);

    // Cycle counter: restart clears it, then counts exactly the run cycles.
    wr(5'd18, 32'h0);
    wr(5'd18, 32'h1);
    rd(5'd23, rdv);
    check("cnt_cleared", {224'b0, rdv}, 256'd0);
    repeat (99) tick();
    miner_irq = 1'b1;
    rd(5'd23, rdv);
    check("cnt_lo", {224'b0, rdv}, {224'b0, 32'd100});
    rd(5'd24, rdv);
    check("cnt_hi", {224'b0, rdv}, 256'd0);
    tick();
    rd(5'd23, rdv);
    check("cnt_hold", {224'b0, rdv}, {224'b0, 32'd100});
    miner_irq = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
